clk_gate_ctrl: RTL and testbench
================================

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter NumReq, default 4: number of requesters/activity sources; legal 1..32.
REQ-002 SHALL have parameter IdleCycles, default 16: consecutive idle cycles before gating; legal >= 1.
REQ-003 SHALL have parameter WakeCycles, default 2: enabled-clock settle cycles before returning to RUN; legal >= 1.
REQ-004 SHALL have parameter CntWidth, default 16: width of the gated-cycle statistic counter.
REQ-005 SHALL have port clk_i, input, 1: free-running clock, the source clock of the gated domain.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port test_en_i, input, 1: forces clk_en_o high; FSM keeps running.
REQ-008 SHALL have port busy_i, input, NumReq: per-source activity, level-sensitive.
REQ-009 SHALL have port req_i, input, NumReq: per-requester wake/use request.
REQ-010 SHALL have port gnt_o, output, NumReq: per-requester grant; gated clock is running and stable.
REQ-011 SHALL have port clk_en_o, output, 1: enable for the downstream ICG en input; registered.
REQ-012 SHALL have port gated_o, output, 1: high while the FSM is in GATED.
REQ-013 SHALL have port clear_stats_i, input, 1: synchronous clear of gated_cycles_o.
REQ-014 SHALL have port gated_cycles_o, output, CntWidth: count of cycles with clk_en_o low.

Function
REQ-015 SHALL implement FSM states RUN, IDLE, GATED, WAKE; "activity" = OR of busy_i and req_i.
REQ-016 RUN: clk_en_o=1; no activity -> IDLE with idle counter = 1; activity -> stay in RUN.
REQ-017 IDLE: clk_en_o=1; activity -> RUN with counter cleared; otherwise counter increments, and at IdleCycles consecutive idle cycles -> GATED.
REQ-018 With IdleCycles=N, clk_en_o SHALL fall in the cycle after the Nth consecutive inactive cycle, counting from the first inactive cycle sampled in RUN.
REQ-019 GATED: clk_en_o=0, gated_o=1; activity -> WAKE, clk_en_o=1 from the next cycle.
REQ-020 WAKE: clk_en_o=1; stays exactly WakeCycles cycles regardless of activity, then -> RUN.
REQ-021 gnt_o[i] SHALL be registered: set the cycle after req_i[i]=1 is sampled in RUN; cleared the cycle after req_i[i]=0; never set outside RUN.
REQ-022 Requesters SHALL hold req_i until gnt_o; dropping req_i before grant is legal and produces no grant.
REQ-023 A held req_i SHALL keep the FSM in RUN, so gnt_o never drops while req_i stays high.
REQ-024 Activity in the same cycle the counter reaches IdleCycles SHALL win: -> RUN, no gating.
REQ-025 test_en_i=1 SHALL force clk_en_o=1 combinationally via OR after the register; gated_o and gnt_o stay FSM-driven.
REQ-026 clk_en_o SHALL change only on clk_i rising edges; the ICG latch covers glitch-freedom.

Reset
REQ-027 While rst_ni=0: state=RUN, counters=0, clk_en_o=1, gated_o=0, gnt_o=0, gated_cycles_o=0.
REQ-028 Reset asserted mid-GATED or mid-WAKE SHALL immediately re-enable the clock, with no handshake.

Configuration
REQ-029 Macro CLK_GATE_CTRL_STATS_EN defined: gated_cycles_o increments each cycle the registered clk_en_o is 0, saturates at all-ones, and clear_stats_i clears it (clear wins over increment).
REQ-030 Macro CLK_GATE_CTRL_STATS_EN undefined: no counter logic; gated_cycles_o tied to 0; clear_stats_i ignored; ports kept.

Verification (NumReq=2, IdleCycles=4, WakeCycles=2)
REQ-031 Reset release with all inputs 0 -> clk_en_o=1 for 4 cycles, 0 from cycle 5; gated_o=1.
REQ-032 busy_i=2'b01 pulses at idle count 4 -> state RUN; clk_en_o never drops.
REQ-033 From GATED, req_i=2'b10 held -> clk_en_o=1 next cycle, WAKE for 2 cycles, gnt_o=2'b10 one cycle after RUN entry.
REQ-034 In GATED, req_i pulsed for 1 cycle -> wake sequence completes, gnt_o stays 0, regating after 4 idle cycles.
REQ-035 test_en_i=1 in GATED -> clk_en_o=1 same cycle, gated_o stays 1; rst_ni low during WAKE -> all outputs at reset values.
REQ-036 STATS_EN, CntWidth=4, 20 gated cycles -> gated_cycles_o=15 (saturated); clear_stats_i pulse -> 0 next cycle.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller: drops the ICG enable after IdleCycles idle cycles, restores it on any busy/req.
// Latency: clk_en_o falls one cycle after the IdleCycles-th idle cycle, rises one cycle after activity; gnt_o is registered (1 cycle in RUN).
// Backpressure: requesters hold req_i until gnt_o; WAKE lasts WakeCycles. CLK_GATE_CTRL_STATS_EN enables the gated-cycle counter.
module clk_gate_ctrl #(
    parameter int NumReq     = 4,
    parameter int IdleCycles = 16,
    parameter int WakeCycles = 2,
    parameter int CntWidth   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                test_en_i,
    input  logic [NumReq-1:0]   busy_i,
    input  logic [NumReq-1:0]   req_i,
    output logic [NumReq-1:0]   gnt_o,
    output logic                clk_en_o,
    output logic                gated_o,
    input  logic                clear_stats_i,
    output logic [CntWidth-1:0] gated_cycles_o
);

    localparam int MaxCnt = (IdleCycles > WakeCycles) ? IdleCycles : WakeCycles;
    localparam int CW     = $clog2(MaxCnt + 1);
    localparam logic [CW-1:0] IdleLast = CW'(IdleCycles - 1);
    localparam logic [CW-1:0] WakeLast = CW'(WakeCycles - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_IDLE,
        ST_GATED,
        ST_WAKE
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic                clk_en_q;
    logic                gated_q;
    logic [NumReq-1:0]   gnt_q;
    logic                activity;

    assign activity = |{busy_i, req_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            clk_en_q <= 1'b1;
            gated_q  <= 1'b0;
            gnt_q    <= '0;
        end else begin
            gnt_q <= (state_q == ST_RUN) ? req_i : '0;
            case (state_q)
                ST_RUN: begin
                    if (!activity) begin
                        // The first idle cycle is sampled here, so a threshold of 1 gates directly.
                        if (IdleCycles == 1) begin
                            state_q  <= ST_GATED;
                            clk_en_q <= 1'b0;
                            gated_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= CW'(1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (activity) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end else if (cnt_q == IdleLast) begin
                        state_q  <= ST_GATED;
                        cnt_q    <= '0;
                        clk_en_q <= 1'b0;
                        gated_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_GATED: begin
                    if (activity) begin
                        state_q  <= ST_WAKE;
                        cnt_q    <= '0;
                        clk_en_q <= 1'b1;
                        gated_q  <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    // Settle time is fixed; activity cannot shorten or extend it.
                    if (cnt_q == WakeLast) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q  <= ST_RUN;
                    cnt_q    <= '0;
                    clk_en_q <= 1'b1;
                    gated_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clk_en_o = clk_en_q | test_en_i;
    assign gated_o  = gated_q;
    assign gnt_o    = gnt_q;

`ifdef CLK_GATE_CTRL_STATS_EN
    logic [CntWidth-1:0] stat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_q <= '0;
        end else if (clear_stats_i) begin
            stat_q <= '0;
        end else if (!clk_en_q && (stat_q != {CntWidth{1'b1}})) begin
            stat_q <= stat_q + CntWidth'(1);
        end
    end

    assign gated_cycles_o = stat_q;
`else
    logic unused_clear_stats;
    assign unused_clear_stats = clear_stats_i;
    assign gated_cycles_o     = '0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed table of per-cycle vectors for clk_gate_ctrl (NumReq=2, IdleCycles=4, WakeCycles=2, CntWidth=4),
// plus hand sequences for combinational test_en and asynchronous reset.
module tb_clk_gate_ctrl;

    logic       clk;
    logic       rst_n;
    logic       test_en;
    logic [1:0] busy;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       clk_en;
    logic       gated;
    logic       clr;
    logic [3:0] gated_cycles;

    int pass_cnt  = 0;
    int total_cnt = 0;

    clk_gate_ctrl #(
        .NumReq    (2),
        .IdleCycles(4),
        .WakeCycles(2),
        .CntWidth  (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .test_en_i     (test_en),
        .busy_i        (busy),
        .req_i         (req),
        .gnt_o         (gnt),
        .clk_en_o      (clk_en),
        .gated_o       (gated),
        .clear_stats_i (clr),
        .gated_cycles_o(gated_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       test_en;
        logic [1:0] busy;
        logic [1:0] req;
        logic       clr;
        logic       exp_en;
        logic       exp_gated;
        logic [1:0] exp_gnt;
        logic [3:0] exp_st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic te, input logic [1:0] b, input logic [1:0] q,
                       input logic c, input logic en, input logic g, input logic [1:0] gn,
                       input int st);
        vec_t v;
        v.rst_n = r; v.test_en = te; v.busy = b; v.req = q; v.clr = c;
        v.exp_en = en; v.exp_gated = g; v.exp_gnt = gn; v.exp_st = 4'(st);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    function automatic logic [3:0] stat_exp(input int st);
`ifdef CLK_GATE_CTRL_STATS_EN
        return 4'(st);
`else
        return 4'(st - st);
`endif
    endfunction

    initial begin
        rst_n = 1'b0; test_en = 1'b0; busy = '0; req = '0; clr = 1'b0;

        // Idle from reset: gated after four idle cycles
        add(1,0,0,0,0, 1,0,0,0); add(1,0,0,0,0, 1,0,0,0); add(1,0,0,0,0, 1,0,0,0);
        add(1,0,0,0,0, 0,1,0,0); add(1,0,0,0,0, 0,1,0,1);
        // Held req wakes, WAKE two cycles, grant one cycle after RUN
        add(1,0,0,2,0, 1,0,0,2); add(1,0,0,2,0, 1,0,0,2); add(1,0,0,2,0, 1,0,0,2);
        add(1,0,0,2,0, 1,0,2,2); add(1,0,0,2,0, 1,0,2,2);
        add(1,0,0,0,0, 1,0,0,2); add(1,0,0,0,0, 1,0,0,2); add(1,0,0,0,0, 1,0,0,2);
        // Busy pulse on what would be the fourth idle cycle keeps clock running
        add(1,0,1,0,0, 1,0,0,2);
        add(1,0,0,0,0, 1,0,0,2); add(1,0,0,0,0, 1,0,0,2); add(1,0,0,0,0, 1,0,0,2);
        add(1,0,0,0,0, 0,1,0,2);
        // test_en overrides enable but not gated_o
        add(1,1,0,0,0, 1,1,0,3); add(1,0,0,0,0, 0,1,0,4);
        // One-cycle req pulse: wake completes, no grant, regates
        add(1,0,0,1,0, 1,0,0,5); add(1,0,0,0,0, 1,0,0,5); add(1,0,0,0,0, 1,0,0,5);
        add(1,0,0,0,0, 1,0,0,5); add(1,0,0,0,0, 1,0,0,5); add(1,0,0,0,0, 1,0,0,5);
        add(1,0,0,0,0, 0,1,0,5);
        // req dropped during WAKE before grant
        add(1,0,0,2,0, 1,0,0,6); add(1,0,0,2,0, 1,0,0,6);
        add(1,0,0,0,0, 1,0,0,6); add(1,0,0,0,0, 1,0,0,6);
        add(1,0,0,0,1, 1,0,0,0); add(1,0,0,0,0, 1,0,0,0); add(1,0,0,0,0, 0,1,0,0);
        // Twenty gated cycles saturate a 4-bit counter
        for (int k = 1; k <= 20; k++) add(1,0,0,0,0, 0,1,0, (k > 15) ? 15 : k);
        add(1,0,0,0,1, 0,1,0,0); add(1,0,0,0,0, 0,1,0,1);
        // Busy during WAKE does not extend it
        add(1,0,1,0,0, 1,0,0,2); add(1,0,1,0,0, 1,0,0,2); add(1,0,1,0,0, 1,0,0,2);
        add(1,0,1,0,0, 1,0,0,2);
        add(1,0,0,0,0, 1,0,0,2); add(1,0,0,0,0, 1,0,0,2); add(1,0,0,0,0, 1,0,0,2);
        add(1,0,0,0,0, 0,1,0,2);
        // Reset during WAKE, then grants track held/dropped req bits
        add(1,0,0,3,0, 1,0,0,3); add(0,0,0,3,0, 1,0,0,0);
        add(1,0,0,3,0, 1,0,3,0); add(1,0,0,3,0, 1,0,3,0); add(1,0,0,1,0, 1,0,1,0);
        add(1,0,0,0,0, 1,0,0,0); add(1,0,0,0,0, 1,0,0,0); add(1,0,0,0,0, 1,0,0,0);
        add(1,0,0,0,0, 0,1,0,0);

        repeat (2) @(posedge clk);
        #1;
        check("reset clk_en", 32'(clk_en), 32'(1'b1));
        check("reset gated", 32'(gated), 32'(1'b0));
        check("reset gnt", 32'(gnt), 32'(2'b00));
        check("reset stats", 32'(gated_cycles), 32'(4'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n   = vecs[i].rst_n;
            test_en = vecs[i].test_en;
            busy    = vecs[i].busy;
            req     = vecs[i].req;
            clr     = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("v%0d clk_en", i + 1), 32'(clk_en), 32'(vecs[i].exp_en));
            check($sformatf("v%0d gated", i + 1), 32'(gated), 32'(vecs[i].exp_gated));
            check($sformatf("v%0d gnt", i + 1), 32'(gnt), 32'(vecs[i].exp_gnt));
            check($sformatf("v%0d stats", i + 1), 32'(gated_cycles), 32'(stat_exp(int'(vecs[i].exp_st))));
        end
        busy = '0; req = '0; clr = 1'b0; test_en = 1'b0;

        // Combinational test_en override within a gated cycle
        test_en = 1'b1;
        #1;
        check("te same-cycle clk_en", 32'(clk_en), 32'(1'b1));
        check("te same-cycle gated", 32'(gated), 32'(1'b1));
        test_en = 1'b0;
        #1;
        check("te release clk_en", 32'(clk_en), 32'(1'b0));

        repeat (2) @(posedge clk);
        #1;
        check("gated stats", 32'(gated_cycles), 32'(stat_exp(2)));

        // Asynchronous reset mid-GATED re-enables without waiting for an edge
        rst_n = 1'b0;
        #1;
        check("async rst clk_en", 32'(clk_en), 32'(1'b1));
        check("async rst gated", 32'(gated), 32'(1'b0));
        check("async rst gnt", 32'(gnt), 32'(2'b00));
        check("async rst stats", 32'(gated_cycles), 32'(4'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post rst idle clk_en", 32'(clk_en), 32'(1'b1));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
